data_mem_port: RTL

- Load/store front end that sits between the MIPS core's memory stage and single_port_ram.
- Accepts one byte, halfword or word request at a time using a valid/ready handshake.
- Translates data-segment byte addresses (base 0x10010000) into RAM word indices.
- Performs read-modify-write for sub-word stores and returns load data with a single-cycle response pulse.

---
 rtl/data_mem_port.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/data_mem_port.sv
// Load/store front end between the core's memory stage and a single-port RAM.
// One request at a time; sub-word stores are done as read-modify-write.
module data_mem_port #(
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int          MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_q_i
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * MEM_WORDS);

    state_t      r_state, w_next;
    logic [1:0]  r_off, r_size;
    logic        r_we, r_uns, r_err;
    logic [31:0] r_wdata, r_ram_addr, r_ram_data, r_rdata;

    logic        w_accept, w_err, w_range_err;
    logic [31:0] w_word_idx, w_merged, w_load;
    logic [4:0]  w_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_accept    = req_valid_i & (r_state == IDLE);
    assign w_range_err = ({1'b0, req_addr_i} < {1'b0, BASE_ADDR}) | ({1'b0, req_addr_i} >= LIMIT);
    assign w_err       = (req_size_i == 2'b11)
                       | ((req_size_i == 2'b01) & req_addr_i[0])
                       | ((req_size_i == 2'b10) & (req_addr_i[1:0] != 2'b00))
                       | w_range_err;
    assign w_word_idx  = (req_addr_i - BASE_ADDR) >> 2;

    // Little-endian lane position; halfwords use only addr[1].
    assign w_sh   = (r_size == 2'b01) ? {r_off[1], 4'b0000} : {r_off, 3'b000};
    assign w_byte = 8'(ram_q_i >> w_sh);
    assign w_half = 16'(ram_q_i >> w_sh);

    always_comb begin
        w_merged = ram_q_i;
        w_load   = ram_q_i;
        case (r_size)
            2'b00: begin
                w_merged = (ram_q_i & ~(32'h000000FF << w_sh)) | ({24'b0, r_wdata[7:0]} << w_sh);
                w_load   = r_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            2'b01: begin
                w_merged = (ram_q_i & ~(32'h0000FFFF << w_sh)) | ({16'b0, r_wdata[15:0]} << w_sh);
                w_load   = r_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (req_valid_i) begin
                if (w_err)                                 w_next = RESP;
                else if (req_we_i && req_size_i == 2'b10)  w_next = WR;
                else                                       w_next = RD;
            end
            RD:      w_next = CAP;
            CAP:     w_next = r_we ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Response fields only change on the edge that enters RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_off      <= '0;
            r_size     <= '0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_wdata    <= '0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_off   <= req_addr_i[1:0];
                r_size  <= req_size_i;
                r_we    <= req_we_i;
                r_uns   <= req_unsigned_i;
                r_wdata <= req_wdata_i;
                if (w_err) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else begin
                    r_ram_addr <= w_word_idx;
                    if (req_we_i && req_size_i == 2'b10) r_ram_data <= req_wdata_i;
                end
            end
            if (r_state == CAP) begin
                if (r_we) begin
                    r_ram_data <= w_merged;
                end else begin
                    r_rdata <= w_load;
                    r_err   <= 1'b0;
                end
            end
            if (r_state == WR) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign req_ready_o  = (r_state == IDLE);
    assign resp_valid_o = (r_state == RESP);
    assign resp_rdata_o = r_rdata;
    assign resp_err_o   = r_err;
    assign ram_we_o     = (r_state == WR);
    assign ram_addr_o   = r_ram_addr;
    assign ram_data_o   = r_ram_data;

endmodule
